vis_axis_packer: RTL

- Sits directly downstream of the visibility correlator chain and consumes its accumulated visibility stream: vis_valid/first/last plus signed real/imag.
- The chain cannot stall, so this block buffers each frame in a FIFO.
- It admits or drops whole frames depending on free space.
- It emits sign-extended {imag, real} words on an AXI4-Stream master, with tlast on the final word of each frame.

---
 rtl/vis_axis_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vis_axis_packer.sv
// Frame-admitting packer: buffers correlator visibility frames in a FIFO and
// emits sign-extended {imag, real} words on an AXI4-Stream master.
module vis_axis_packer #(
  parameter int unsigned IBITS = 7,
  parameter int unsigned OBITS = 16,
  parameter int unsigned FRAME = 15,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CBITS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         vis_valid_i,
  input  logic                         vis_first_i,
  input  logic                         vis_last_i,
  input  logic [IBITS-1:0]             vis_real_i,
  input  logic [IBITS-1:0]             vis_imag_i,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic [2*OBITS-1:0]           m_tdata,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic [CBITS-1:0]             drops_o,
  output logic                         error_o
);

  localparam int unsigned LBITS = $clog2(DEPTH + 1);
  localparam int unsigned PBITS = $clog2(DEPTH);
  localparam int unsigned WBITS = $clog2(FRAME + 1);
  localparam int unsigned EBITS = 2 * IBITS + 1;

  localparam logic [LBITS-1:0] DepthL    = LBITS'(DEPTH);
  localparam logic [LBITS-1:0] AdmitMax  = LBITS'(DEPTH - FRAME);
  localparam logic [WBITS-1:0] FrameW    = WBITS'(FRAME);

  typedef enum logic [1:0] {StIdle, StAccept, StDrop} state_e;

  state_e             state_q, state_d;
  logic [WBITS-1:0]   wcnt_q, wcnt_d;
  logic               error_q, error_d;
  logic [CBITS-1:0]   drops_q, drops_d;
  logic [PBITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PBITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LBITS-1:0]   mem_cnt_q, mem_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [EBITS-1:0]   out_q, out_d;
  logic [EBITS-1:0]   mem_q [DEPTH];

  logic               wr_req, wr_en, rd_en, admit;
  logic [EBITS-1:0]   wr_data;
  logic [OBITS-1:0]   real_sx, imag_sx;

  // Occupancy includes the word parked in the output register.
  assign level_o = mem_cnt_q + LBITS'(out_valid_q);
  assign admit   = (level_o <= AdmitMax);
  assign wr_data = {vis_last_i, vis_imag_i, vis_real_i};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    error_d = error_q;
    drops_d = drops_q;
    wr_req  = 1'b0;
    if (vis_valid_i) begin
      if (vis_first_i) begin
        // A first outside IDLE means the previous frame lost its last word.
        if (state_q != StIdle) error_d = 1'b1;
        if (admit) begin
          wr_req  = 1'b1;
          wcnt_d  = WBITS'(1);
          state_d = vis_last_i ? StIdle : StAccept;
        end else begin
          if (drops_q != {CBITS{1'b1}}) drops_d = drops_q + 1'b1;
          state_d = vis_last_i ? StIdle : StDrop;
        end
      end else begin
        unique case (state_q)
          StIdle: error_d = 1'b1;
          StAccept: begin
            if (wcnt_q < FrameW) begin
              wr_req = 1'b1;
              wcnt_d = wcnt_q + 1'b1;
            end else begin
              error_d = 1'b1;
            end
            if (vis_last_i) state_d = StIdle;
          end
          StDrop: begin
            if (vis_last_i) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    wr_en       = wr_req && (mem_cnt_q != DepthL);
    rd_en       = (mem_cnt_q != '0) && (!out_valid_q || m_tready);
    wr_ptr_d    = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    if (wr_en && !rd_en) mem_cnt_d = mem_cnt_q + 1'b1;
    if (!wr_en && rd_en) mem_cnt_d = mem_cnt_q - 1'b1;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (rd_en) begin
      out_valid_d = 1'b1;
      out_d       = mem_q[rd_ptr_q];
    end else if (m_tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      error_q     <= 1'b0;
      drops_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      error_q     <= error_d;
      drops_q     <= drops_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    real_sx            = {OBITS{out_q[IBITS-1]}};
    real_sx[IBITS-1:0] = out_q[IBITS-1:0];
    imag_sx            = {OBITS{out_q[2*IBITS-1]}};
    imag_sx[IBITS-1:0] = out_q[2*IBITS-1:IBITS];
  end

  assign m_tvalid = out_valid_q;
  assign m_tlast  = out_valid_q & out_q[EBITS-1];
  assign m_tdata  = {imag_sx, real_sx};
  assign drops_o  = drops_q;
  assign error_o  = error_q;

endmodule
